// File: rtl/md_io_pkg.sv
// Shared register map, reset constants and per-port register bundle for md_io_regs.
// Build option MD_IO_TH_IRQ_EN enables TH falling-edge interrupt detection.
package md_io_pkg;

    localparam logic [3:0] REG_VER     = 4'h0;
    localparam logic [3:0] REG_DATA1   = 4'h1;
    localparam logic [3:0] REG_DATA2   = 4'h2;
    localparam logic [3:0] REG_DATA3   = 4'h3;
    localparam logic [3:0] REG_CTRL1   = 4'h4;
    localparam logic [3:0] REG_CTRL2   = 4'h5;
    localparam logic [3:0] REG_CTRL3   = 4'h6;
    localparam logic [3:0] REG_TXDATA1 = 4'h7;
    localparam logic [3:0] REG_RXDATA1 = 4'h8;
    localparam logic [3:0] REG_SCTRL1  = 4'h9;
    localparam logic [3:0] REG_TXDATA2 = 4'hA;
    localparam logic [3:0] REG_RXDATA2 = 4'hB;
    localparam logic [3:0] REG_SCTRL2  = 4'hC;
    localparam logic [3:0] REG_TXDATA3 = 4'hD;
    localparam logic [3:0] REG_RXDATA3 = 4'hE;
    localparam logic [3:0] REG_SCTRL3  = 4'hF;

    localparam logic [7:0] CTRL_RST  = 8'h00;
    localparam logic [7:0] TX_RST    = 8'hFF;
    localparam logic [7:0] RX_RST    = 8'h00;
    localparam logic [7:0] SCTRL_RST = 8'h00;
    localparam logic [7:0] DO_RST    = 8'h00;

    typedef enum logic [2:0] {
        FLD_DATA,
        FLD_CTRL,
        FLD_TX,
        FLD_RX,
        FLD_SCTRL
    } field_t;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] ctrl;
        logic [7:0] tx;
        logic [7:0] sctrl;
    } port_regs_t;

endpackage

// File: rtl/md_io_port.sv
// One controller port: DATA/CTRL/TX/SCTRL storage, pad drive, read mux and TH edge.
// Build option MD_IO_TH_IRQ_EN adds the th_edge output and its TH history flop.
module md_io_port
    import md_io_pkg::*;
#(
    parameter logic [7:0] DATA_RST = 8'h7F
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MD_IO_TH_IRQ_EN
    output logic       th_edge,
`endif
    input  logic       wr_en,
    input  field_t     field,
    input  logic [7:0] wr_data,
    input  logic [6:0] pad_in,
    output logic [6:0] pad_out,
    output logic [6:0] pad_dir,
    output logic [7:0] rd_data
);

    port_regs_t regs;

    always_ff @(posedge clk) begin
        if (reset) begin
            regs.data  <= DATA_RST;
            regs.ctrl  <= CTRL_RST;
            regs.tx    <= TX_RST;
            regs.sctrl <= SCTRL_RST;
        end else if (wr_en) begin
            case (field)
                FLD_DATA:  regs.data  <= wr_data;
                FLD_CTRL:  regs.ctrl  <= wr_data;
                FLD_TX:    regs.tx    <= wr_data;
                FLD_SCTRL: regs.sctrl <= wr_data;
                default:   ;
            endcase
        end
    end

    assign pad_out = regs.data[6:0];
    assign pad_dir = regs.ctrl[6:0];

    // Output bits read back the latch, input bits read the live pad level.
    always_comb begin
        rd_data = '0;
        case (field)
            FLD_DATA:  rd_data = {regs.data[7],
                                  (regs.ctrl[6:0] & regs.data[6:0]) | (~regs.ctrl[6:0] & pad_in)};
            FLD_CTRL:  rd_data = regs.ctrl;
            FLD_TX:    rd_data = regs.tx;
            FLD_RX:    rd_data = RX_RST;
            FLD_SCTRL: rd_data = regs.sctrl;
            default:   rd_data = '0;
        endcase
    end

`ifdef MD_IO_TH_IRQ_EN
    logic th_prev;

    always_ff @(posedge clk) begin
        if (reset) th_prev <= 1'b0;
        else       th_prev <= pad_in[6];
    end

    assign th_edge = th_prev & ~pad_in[6] & ~regs.ctrl[6] & regs.ctrl[7];
`endif

endmodule

// File: rtl/md_io_regs.sv
// 68k I/O controller register window: address decode, read register, ack and HL irq.
// Build option MD_IO_TH_IRQ_EN enables hl_irq; otherwise it is tied low.
module md_io_regs
    import md_io_pkg::*;
#(
    parameter logic [3:0] HW_VER   = 4'h0,
    parameter logic [7:0] DATA_RST = 8'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       export_n,
    input  logic       pal,
    input  logic       exp_n,
    input  logic       cpu_sel,
    input  logic       cpu_we,
    input  logic [3:0] cpu_a,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       cpu_ack,
    input  logic [6:0] pad1_in,
    input  logic [6:0] pad2_in,
    input  logic [6:0] pad3_in,
    output logic [6:0] pad1_out,
    output logic [6:0] pad2_out,
    output logic [6:0] pad3_out,
    output logic [6:0] pad1_dir,
    output logic [6:0] pad2_dir,
    output logic [6:0] pad3_dir,
    output logic       hl_irq,
    input  logic       irq_ack
);

    logic [1:0] port_sel;
    field_t     field;
    logic       ver_sel;
    logic [2:0] wr_en;
    logic [7:0] rd_data [3];
    logic [7:0] rd_mux;
    logic [7:0] ver_byte;
    logic       ack_q;

    always_comb begin
        port_sel = 2'd0;
        field    = FLD_DATA;
        ver_sel  = 1'b0;
        case (cpu_a)
            REG_VER:     ver_sel = 1'b1;
            REG_DATA1:   begin port_sel = 2'd0; field = FLD_DATA;  end
            REG_DATA2:   begin port_sel = 2'd1; field = FLD_DATA;  end
            REG_DATA3:   begin port_sel = 2'd2; field = FLD_DATA;  end
            REG_CTRL1:   begin port_sel = 2'd0; field = FLD_CTRL;  end
            REG_CTRL2:   begin port_sel = 2'd1; field = FLD_CTRL;  end
            REG_CTRL3:   begin port_sel = 2'd2; field = FLD_CTRL;  end
            REG_TXDATA1: begin port_sel = 2'd0; field = FLD_TX;    end
            REG_RXDATA1: begin port_sel = 2'd0; field = FLD_RX;    end
            REG_SCTRL1:  begin port_sel = 2'd0; field = FLD_SCTRL; end
            REG_TXDATA2: begin port_sel = 2'd1; field = FLD_TX;    end
            REG_RXDATA2: begin port_sel = 2'd1; field = FLD_RX;    end
            REG_SCTRL2:  begin port_sel = 2'd1; field = FLD_SCTRL; end
            REG_TXDATA3: begin port_sel = 2'd2; field = FLD_TX;    end
            REG_RXDATA3: begin port_sel = 2'd2; field = FLD_RX;    end
            REG_SCTRL3:  begin port_sel = 2'd2; field = FLD_SCTRL; end
            default:     ;
        endcase
    end

    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            wr_en[i] = cpu_sel & cpu_we & ~ver_sel & (port_sel == 2'(i));
        end
    end

`ifdef MD_IO_TH_IRQ_EN
    logic [2:0] th_edge;
`endif

    md_io_port #(.DATA_RST(DATA_RST)) u_port1 (
        .clk     (clk),
        .reset   (reset),
`ifdef MD_IO_TH_IRQ_EN
        .th_edge (th_edge[0]),
`endif
        .wr_en   (wr_en[0]),
        .field   (field),
        .wr_data (cpu_di),
        .pad_in  (pad1_in),
        .pad_out (pad1_out),
        .pad_dir (pad1_dir),
        .rd_data (rd_data[0])
    );

    md_io_port #(.DATA_RST(DATA_RST)) u_port2 (
        .clk     (clk),
        .reset   (reset),
`ifdef MD_IO_TH_IRQ_EN
        .th_edge (th_edge[1]),
`endif
        .wr_en   (wr_en[1]),
        .field   (field),
        .wr_data (cpu_di),
        .pad_in  (pad2_in),
        .pad_out (pad2_out),
        .pad_dir (pad2_dir),
        .rd_data (rd_data[1])
    );

    md_io_port #(.DATA_RST(DATA_RST)) u_port3 (
        .clk     (clk),
        .reset   (reset),
`ifdef MD_IO_TH_IRQ_EN
        .th_edge (th_edge[2]),
`endif
        .wr_en   (wr_en[2]),
        .field   (field),
        .wr_data (cpu_di),
        .pad_in  (pad3_in),
        .pad_out (pad3_out),
        .pad_dir (pad3_dir),
        .rd_data (rd_data[2])
    );

    assign ver_byte = {~export_n, pal, exp_n, 1'b0, HW_VER};

    always_comb begin
        rd_mux = ver_byte;
        if (!ver_sel) begin
            case (port_sel)
                2'd0:    rd_mux = rd_data[0];
                2'd1:    rd_mux = rd_data[1];
                default: rd_mux = rd_data[2];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q  <= 1'b0;
            cpu_do <= DO_RST;
        end else begin
            ack_q <= cpu_sel;
            if (cpu_sel) cpu_do <= rd_mux;
        end
    end

    // Gating with reset suppresses an ack already queued when reset arrives mid-access.
    assign cpu_ack = ack_q & ~reset;

`ifdef MD_IO_TH_IRQ_EN
    // A new edge wins over a simultaneous acknowledge.
    always_ff @(posedge clk) begin
        if (reset)          hl_irq <= 1'b0;
        else if (|th_edge)  hl_irq <= 1'b1;
        else if (irq_ack)   hl_irq <= 1'b0;
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign hl_irq         = 1'b0;
`endif

endmodule

// File: tb/tb_md_io_regs.sv
// Self-checking bench for md_io_regs: behavioural register-map model plus directed vectors.
// Expectations for hl_irq follow the MD_IO_TH_IRQ_EN build option.
module tb_md_io_regs;

`ifdef MD_IO_TH_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       export_n, pal, exp_n;
    logic       cpu_sel, cpu_we;
    logic [3:0] cpu_a;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       cpu_ack;
    logic [6:0] pad1_in, pad2_in, pad3_in;
    logic [6:0] pad1_out, pad2_out, pad3_out;
    logic [6:0] pad1_dir, pad2_dir, pad3_dir;
    logic       hl_irq;
    logic       irq_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    md_io_regs #(.HW_VER(4'h0), .DATA_RST(8'h7F)) dut (
        .clk      (clk),
        .reset    (reset),
        .export_n (export_n),
        .pal      (pal),
        .exp_n    (exp_n),
        .cpu_sel  (cpu_sel),
        .cpu_we   (cpu_we),
        .cpu_a    (cpu_a),
        .cpu_di   (cpu_di),
        .cpu_do   (cpu_do),
        .cpu_ack  (cpu_ack),
        .pad1_in  (pad1_in),
        .pad2_in  (pad2_in),
        .pad3_in  (pad3_in),
        .pad1_out (pad1_out),
        .pad2_out (pad2_out),
        .pad3_out (pad3_out),
        .pad1_dir (pad1_dir),
        .pad2_dir (pad2_dir),
        .pad3_dir (pad3_dir),
        .hl_irq   (hl_irq),
        .irq_ack  (irq_ack)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_data [3];
    logic [7:0] m_ctrl [3];
    logic [7:0] m_tx   [3];
    logic [7:0] m_sctrl[3];
    bit         m_th   [3];
    bit         m_irq;
    bit         m_ack;
    logic [7:0] m_do;
    bit         started = 1'b0;

    function automatic logic [6:0] pin(input int p);
        if (p == 0) return pad1_in;
        if (p == 1) return pad2_in;
        return pad3_in;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        int idx;
        int p;
        logic [6:0] pv;
        logic [7:0] v;
        idx = int'(a);
        if (idx == 0) return {~export_n, pal, exp_n, 1'b0, 4'h0};
        if (idx <= 3) begin
            p  = idx - 1;
            pv = pin(p);
            v  = m_data[p];
            for (int i = 0; i < 7; i++) if (!m_ctrl[p][i]) v[i] = pv[i];
            return v;
        end
        if (idx <= 6) return m_ctrl[idx - 4];
        p = (idx - 7) / 3;
        case ((idx - 7) % 3)
            0:       return m_tx[p];
            1:       return 8'h00;
            default: return m_sctrl[p];
        endcase
    endfunction

    task automatic m_write(input logic [3:0] a, input logic [7:0] d);
        int idx;
        int p;
        idx = int'(a);
        if (idx == 0) return;
        if (idx <= 3) begin m_data[idx - 1] = d; return; end
        if (idx <= 6) begin m_ctrl[idx - 4] = d; return; end
        p = (idx - 7) / 3;
        case ((idx - 7) % 3)
            0:       m_tx[p] = d;
            1:       ;
            default: m_sctrl[p] = d;
        endcase
    endtask

    always @(posedge clk) begin
        bit any_edge;
        logic [6:0] pv;
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                m_data[p] = 8'h7F; m_ctrl[p] = 8'h00; m_tx[p] = 8'hFF; m_sctrl[p] = 8'h00;
                m_th[p] = 1'b0;
            end
            m_irq = 1'b0; m_ack = 1'b0; m_do = 8'h00;
            started = 1'b1;
        end else begin
            any_edge = 1'b0;
            for (int p = 0; p < 3; p++) begin
                pv = pin(p);
                if (IRQ_ON && m_th[p] && !pv[6] && !m_ctrl[p][6] && m_ctrl[p][7]) any_edge = 1'b1;
                m_th[p] = pv[6];
            end
            if (any_edge)     m_irq = 1'b1;
            else if (irq_ack) m_irq = 1'b0;
            m_ack = cpu_sel;
            if (cpu_sel) begin
                m_do = m_read(cpu_a);
                if (cpu_we) m_write(cpu_a, cpu_di);
            end
        end
    end

    // Single compare process, every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (started) begin
            chk("ack",    {7'b0, cpu_ack}, {7'b0, (m_ack && !reset)});
            chk("do",     cpu_do, m_do);
            chk("p1_out", {1'b0, pad1_out}, {1'b0, m_data[0][6:0]});
            chk("p2_out", {1'b0, pad2_out}, {1'b0, m_data[1][6:0]});
            chk("p3_out", {1'b0, pad3_out}, {1'b0, m_data[2][6:0]});
            chk("p1_dir", {1'b0, pad1_dir}, {1'b0, m_ctrl[0][6:0]});
            chk("p2_dir", {1'b0, pad2_dir}, {1'b0, m_ctrl[1][6:0]});
            chk("p3_dir", {1'b0, pad3_dir}, {1'b0, m_ctrl[2][6:0]});
            chk("hl_irq", {7'b0, hl_irq}, {7'b0, m_irq});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        tick();
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_a = a; cpu_di = d;
        tick();
        cpu_sel = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        tick();
        cpu_sel = 1'b1; cpu_we = 1'b0; cpu_a = a;
        tick();
        cpu_sel = 1'b0;
        #1;
        chk({name, "_ack"}, {7'b0, cpu_ack}, 8'h01);
        chk(name, cpu_do, exp);
    endtask

    initial begin
        reset = 1'b1; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_a = 4'h0; cpu_di = 8'h00;
        export_n = 1'b0; pal = 1'b1; exp_n = 1'b1;
        pad1_in = 7'h7F; pad2_in = 7'h7F; pad3_in = 7'h7F; irq_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_ack",  {7'b0, cpu_ack}, 8'h00);
        chk("rst_do",   cpu_do, 8'h00);
        chk("rst_p1o",  {1'b0, pad1_out}, 8'h7F);
        chk("rst_p1d",  {1'b0, pad1_dir}, 8'h00);
        chk("rst_irq",  {7'b0, hl_irq}, 8'h00);

        rd(4'h0, 8'hE0, "ver");
        tick(); #1;
        chk("ack_one_cycle", {7'b0, cpu_ack}, 8'h00);

        // Mixed-direction DATA1 read-back.
        wr(4'h4, 8'h40);
        wr(4'h1, 8'h40);
        pad1_in = 7'h3F;
        #1;
        chk("p1_dir_40", {1'b0, pad1_dir}, 8'h40);
        chk("p1_out_40", {1'b0, pad1_out}, 8'h40);
        rd(4'h1, 8'h7F, "data1_mix");

        // TH fall on port 2 with interrupt enabled.
        wr(4'h5, 8'h80);
        pad2_in = 7'h3F;
        tick(); #1;
        chk("irq_set", {7'b0, hl_irq}, {7'b0, IRQ_ON});
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        #1;
        chk("irq_clr", {7'b0, hl_irq}, 8'h00);
        rd(4'h5, 8'h80, "ctrl2");

        // Ack coincident with a new port-3 edge keeps the request.
        wr(4'h6, 8'h80);
        pad2_in = 7'h7F;
        tick();
        pad2_in = 7'h3F;
        tick();
        pad3_in = 7'h3F; irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        #1;
        chk("irq_ack_vs_edge", {7'b0, hl_irq}, {7'b0, IRQ_ON});
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        #1;
        chk("irq_clr2", {7'b0, hl_irq}, 8'h00);

        // TH driven as output: no interrupt.
        wr(4'h4, 8'hC0);
        pad1_in = 7'h7F;
        tick(); tick();
        pad1_in = 7'h3F;
        tick(); tick(); #1;
        chk("th_out_no_irq", {7'b0, hl_irq}, 8'h00);

        wr(4'h8, 8'h55);
        rd(4'h8, 8'h00, "rx1_ro");
        rd(4'h7, 8'hFF, "tx1_rst");
        wr(4'hA, 8'hA5);
        rd(4'hA, 8'hA5, "tx2");
        wr(4'hF, 8'h3C);
        rd(4'hF, 8'h3C, "sctrl3");
        wr(4'h2, 8'h81);
        rd(4'h2, 8'hBF, "data2_b7");

        // Back-to-back strobes.
        tick();
        cpu_sel = 1'b1; cpu_we = 1'b0; cpu_a = 4'h0;
        tick();
        cpu_a = 4'h5;
        #1;
        chk("b2b_first", cpu_do, 8'hE0);
        tick();
        cpu_sel = 1'b0;
        #1;
        chk("b2b_second_ack", {7'b0, cpu_ack}, 8'h01);
        chk("b2b_second", cpu_do, 8'h80);

        // Reset on the cycle after a read strobe.
        pad1_in = 7'h7F;
        tick();
        cpu_sel = 1'b1; cpu_we = 1'b0; cpu_a = 4'h1;
        tick();
        cpu_sel = 1'b0; reset = 1'b1;
        #1;
        chk("ack_in_reset", {7'b0, cpu_ack}, 8'h00);
        tick();
        reset = 1'b0;
        #1;
        chk("ack_after_reset", {7'b0, cpu_ack}, 8'h00);
        chk("p1_dir_after_reset", {1'b0, pad1_dir}, 8'h00);
        rd(4'h1, 8'h7F, "data1_after_rst");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
